// File: rtl/matmul_host_sequencer_pkg.sv
// rtl/matmul_host_sequencer_pkg.sv - shared FSM encoding and default sizing for the host sequencer
package matmul_host_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

  localparam int DEF_DWIDTH          = 16;
  localparam int DEF_AWIDTH          = 7;
  localparam int DEF_BB_MAT_MUL_SIZE = 16;
  localparam int DEF_NUM_TILES       = 2;
  localparam int DEF_C_DEPTH         = 16;
  localparam int BANK_W              = 3;

endpackage

// File: rtl/matmul_out_skid.sv
// rtl/matmul_out_skid.sv - 2-entry output buffer with valid/ready on both sides
module matmul_out_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  // A full buffer still accepts when its head leaves in the same cycle.
  assign in_ready_o  = (count_q != 2'd2) || out_ready_i;
  assign out_valid_o = (count_q != 2'd0);
  assign out_data_o  = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= in_data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/matmul_host_sequencer.sv
// rtl/matmul_host_sequencer.sv - host write path, compute handshake and C-bank drain sequencer
module matmul_host_sequencer
  import matmul_host_sequencer_pkg::*;
#(
  parameter int DWIDTH          = DEF_DWIDTH,
  parameter int AWIDTH          = DEF_AWIDTH,
  parameter int BB_MAT_MUL_SIZE = DEF_BB_MAT_MUL_SIZE,
  parameter int NUM_TILES       = DEF_NUM_TILES,
  parameter int C_DEPTH         = DEF_C_DEPTH
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    host_wr_valid,
  output logic                                    host_wr_ready,
  input  logic                                    host_wr_mat,
  input  logic [BANK_W-1:0]                       host_wr_bank,
  input  logic [AWIDTH-1:0]                       host_wr_addr,
  input  logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]       host_wr_data,
  input  logic                                    start,
  output logic                                    busy,
  output logic                                    start_mat_mul,
  input  logic                                    done_mat_mul,
  output logic [NUM_TILES-1:0]                    a_we,
  output logic [NUM_TILES-1:0]                    b_we,
  output logic [AWIDTH-1:0]                       mem_addr,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]       mem_wdata,
  output logic [AWIDTH-1:0]                       c_addr,
  input  logic [NUM_TILES*BB_MAT_MUL_SIZE*DWIDTH-1:0] c_q,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [BB_MAT_MUL_SIZE*DWIDTH-1:0]       out_data,
  output logic                                    out_last,
  output logic                                    error
);

  localparam int                WORD_W    = BB_MAT_MUL_SIZE * DWIDTH;
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(C_DEPTH - 1);
  localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_TILES - 1);

  state_e               state_q;
  logic [NUM_TILES-1:0] a_we_q;
  logic [NUM_TILES-1:0] b_we_q;
  logic [AWIDTH-1:0]    mem_addr_q;
  logic [WORD_W-1:0]    mem_wdata_q;
  logic                 start_mat_mul_q;
  logic                 error_q;
  logic [AWIDTH-1:0]    addr_q;
  logic [BANK_W-1:0]    bank_q;
  logic                 issued_all_q;
  logic                 inflight_q;
  logic [BANK_W-1:0]    infl_bank_q;
  logic                 infl_last_q;

  logic                 wr_fire;
  logic                 final_word;
  logic                 issue;
  logic                 skid_in_ready;
  logic                 skid_pop;
  logic [1:0]           skid_count;
  logic [WORD_W:0]      skid_in_data;
  logic [WORD_W:0]      skid_out_data;

  assign host_wr_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign start_mat_mul = start_mat_mul_q;
  assign a_we          = a_we_q;
  assign b_we          = b_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign c_addr        = addr_q;
  assign error         = error_q;
  assign out_data      = skid_out_data[WORD_W-1:0];
  assign out_last      = skid_out_data[WORD_W];

  assign wr_fire    = host_wr_valid && host_wr_ready;
  assign final_word = (bank_q == LAST_BANK) && (addr_q == LAST_ADDR);
  assign skid_pop   = out_valid && out_ready;

  // Words already buffered plus the one returning from the BRAM must fit in two slots.
  assign issue = (state_q == ST_DRAIN) && !issued_all_q && skid_in_ready &&
                 ((int'(skid_count) + int'(inflight_q) - int'(skid_pop)) < 2);

  assign skid_in_data = {infl_last_q, c_q[int'(infl_bank_q)*WORD_W +: WORD_W]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      a_we_q          <= '0;
      b_we_q          <= '0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      start_mat_mul_q <= 1'b0;
      error_q         <= 1'b0;
      addr_q          <= '0;
      bank_q          <= '0;
      issued_all_q    <= 1'b0;
      inflight_q      <= 1'b0;
      infl_bank_q     <= '0;
      infl_last_q     <= 1'b0;
    end else begin
      a_we_q     <= '0;
      b_we_q     <= '0;
      inflight_q <= issue;

      if (wr_fire) begin
        if (int'(host_wr_bank) < NUM_TILES) begin
          mem_addr_q  <= host_wr_addr;
          mem_wdata_q <= host_wr_data;
          if (host_wr_mat) b_we_q <= NUM_TILES'(1) << host_wr_bank;
          else             a_we_q <= NUM_TILES'(1) << host_wr_bank;
        end else begin
          error_q <= 1'b1;
        end
      end

      if (start && busy) error_q <= 1'b1;

      if (issue) begin
        infl_bank_q <= bank_q;
        infl_last_q <= final_word;
        if (final_word) begin
          issued_all_q <= 1'b1;
        end else if (addr_q == LAST_ADDR) begin
          addr_q <= '0;
          bank_q <= bank_q + BANK_W'(1);
        end else begin
          addr_q <= addr_q + AWIDTH'(1);
        end
      end

      case (state_q)
        ST_IDLE: if (start) begin
          state_q         <= ST_COMPUTE;
          start_mat_mul_q <= 1'b1;
        end
        ST_COMPUTE: if (done_mat_mul) begin
          state_q         <= ST_DRAIN;
          start_mat_mul_q <= 1'b0;
        end
        ST_DRAIN: if (skid_pop && out_last) begin
          state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          state_q      <= ST_IDLE;
          addr_q       <= '0;
          bank_q       <= '0;
          issued_all_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  matmul_out_skid #(
    .WIDTH(WORD_W + 1)
  ) u_out_skid (
    .clk        (clk),
    .reset      (reset),
    .in_valid_i (inflight_q),
    .in_ready_o (skid_in_ready),
    .in_data_i  (skid_in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (skid_out_data),
    .count_o    (skid_count)
  );

endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb/tb_matmul_host_sequencer.sv - randomized self-checking bench for matmul_host_sequencer
module tb_matmul_host_sequencer;

  localparam int WORD_W = 256;
  localparam int NT     = 2;
  localparam int DEPTH  = 16;
  localparam int NWORDS = NT * DEPTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 host_wr_valid, host_wr_ready, host_wr_mat;
  logic [2:0]           host_wr_bank;
  logic [6:0]           host_wr_addr;
  logic [WORD_W-1:0]    host_wr_data;
  logic                 start, busy, start_mat_mul, done_mat_mul;
  logic [NT-1:0]        a_we, b_we;
  logic [6:0]           mem_addr, c_addr;
  logic [WORD_W-1:0]    mem_wdata, out_data;
  logic [NT*WORD_W-1:0] c_q;
  logic                 out_valid, out_ready, out_last, error;

  logic                 s_host_wr_ready, s_start, s_busy, s_start_mat_mul, s_done;
  logic [0:0]           s_a_we, s_b_we;
  logic [6:0]           s_mem_addr, s_c_addr;
  logic [WORD_W-1:0]    s_mem_wdata, s_out_data, s_c_q;
  logic                 s_out_valid, s_out_ready, s_out_last, s_error;
  logic                 s_wr_valid, s_wr_mat;
  logic [2:0]           s_wr_bank;
  logic [6:0]           s_wr_addr;
  logic [WORD_W-1:0]    s_wr_data;

  logic [15:0] salt;
  logic        exp_error;
  int          vectors = 0;
  int          miscompares = 0;

  matmul_host_sequencer dut (
    .clk(clk), .reset(reset),
    .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready), .host_wr_mat(host_wr_mat),
    .host_wr_bank(host_wr_bank), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .start(start), .busy(busy), .start_mat_mul(start_mat_mul), .done_mat_mul(done_mat_mul),
    .a_we(a_we), .b_we(b_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .c_addr(c_addr), .c_q(c_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .error(error)
  );

  matmul_host_sequencer #(.NUM_TILES(1), .C_DEPTH(1)) dut_small (
    .clk(clk), .reset(reset),
    .host_wr_valid(s_wr_valid), .host_wr_ready(s_host_wr_ready), .host_wr_mat(s_wr_mat),
    .host_wr_bank(s_wr_bank), .host_wr_addr(s_wr_addr), .host_wr_data(s_wr_data),
    .start(s_start), .busy(s_busy), .start_mat_mul(s_start_mat_mul), .done_mat_mul(s_done),
    .a_we(s_a_we), .b_we(s_b_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .c_addr(s_c_addr), .c_q(s_c_q),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_last(s_out_last),
    .error(s_error)
  );

  // Content every C bank holds: tagged by bank, address and element, scrambled by a per-run salt.
  function automatic logic [WORD_W-1:0] cword(input int bank, input int addr, input logic [15:0] s);
    logic [WORD_W-1:0] w;
    for (int e = 0; e < 16; e++) w[e*16 +: 16] = 16'(bank*4096 + addr*16 + e) ^ s;
    return w;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < NT; k++) c_q[k*WORD_W +: WORD_W] <= cword(k, int'(c_addr), salt);
    s_c_q <= cword(0, int'(s_c_addr), salt);
  end

  task automatic test_reset();
    reset = 1'b1;
    #3;
    vectors++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || start_mat_mul !== 1'b0 || a_we !== '0 ||
        b_we !== '0 || error !== 1'b0 || c_addr !== '0 || out_last !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid=%b busy=%b smm=%b a_we=%b b_we=%b err=%b c_addr=%0d last=%b, required all 0",
               out_valid, busy, start_mat_mul, a_we, b_we, error, c_addr, out_last);
    end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    vectors++;
    if (host_wr_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: host_wr_ready=%b busy=%b, required 1/0", host_wr_ready, busy);
    end
  endtask

  task automatic do_write(input logic mat, input logic [2:0] bank, input logic [6:0] addr,
                          input logic [WORD_W-1:0] data, input string name);
    logic [NT-1:0] exp_a, exp_b;
    exp_a = '0; exp_b = '0;
    if (bank < NT) begin
      if (mat) exp_b[bank] = 1'b1; else exp_a[bank] = 1'b1;
    end else begin
      exp_error = 1'b1;
    end
    host_wr_valid = 1'b1; host_wr_mat = mat; host_wr_bank = bank;
    host_wr_addr = addr; host_wr_data = data;
    @(negedge clk);
    host_wr_valid = 1'b0;
    vectors++;
    if (a_we !== exp_a || b_we !== exp_b || error !== exp_error ||
        (bank < NT && (mem_addr !== addr || mem_wdata !== data))) begin
      miscompares++;
      $display("FAIL %s_pulse: a_we=%b b_we=%b addr=%0d err=%b, required a_we=%b b_we=%b addr=%0d err=%b",
               name, a_we, b_we, mem_addr, error, exp_a, exp_b, addr, exp_error);
    end
    @(negedge clk);
    vectors++;
    if (a_we !== '0 || b_we !== '0) begin
      miscompares++;
      $display("FAIL %s_single_cycle: a_we=%b b_we=%b, required 0", name, a_we, b_we);
    end
  endtask

  task automatic test_host_write();
    do_write(1'b0, 3'd1, 7'd5, {16{16'h1234}}, "write_a1_addr5");
    for (int i = 0; i < 6; i++)
      do_write(1'($urandom % 2), 3'($urandom % NT), 7'($urandom),
               {8{32'($urandom)}}, "write_random");
  endtask

  task automatic run_drain(input bit rand_ready, input bit poke_start, input int reset_at,
                           input bit with_write);
    int idx, cyc, first_cyc, gaps, last_acc, limit;
    bit stalled;
    logic [WORD_W-1:0] held, wdata;
    salt = 16'($urandom);
    limit = (reset_at > 0) ? reset_at : NWORDS;
    wdata = {8{32'($urandom)}};
    start = 1'b1;
    if (with_write) begin
      host_wr_valid = 1'b1; host_wr_mat = 1'b1; host_wr_bank = 3'd0;
      host_wr_addr = 7'd9; host_wr_data = wdata;
    end
    @(negedge clk);
    start = 1'b0; host_wr_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1 || start_mat_mul !== 1'b1 || host_wr_ready !== 1'b0 ||
        (with_write && (b_we !== 2'b01 || mem_addr !== 7'd9 || mem_wdata !== wdata))) begin
      miscompares++;
      $display("FAIL compute_entry: busy=%b smm=%b ready=%b b_we=%b, required 1/1/0/%b",
               busy, start_mat_mul, host_wr_ready, b_we, with_write ? 2'b01 : 2'b00);
    end
    if (poke_start) begin
      exp_error = 1'b1;
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      vectors++;
      if (error !== 1'b1 || start_mat_mul !== 1'b1 || a_we !== '0 || b_we !== '0) begin
        miscompares++;
        $display("FAIL start_in_compute: err=%b smm=%b, required 1/1", error, start_mat_mul);
      end
    end
    repeat (38) @(negedge clk);
    done_mat_mul = 1'b1;
    idx = 0; cyc = 0; first_cyc = 0; gaps = 0; last_acc = 0; stalled = 1'b0; held = '0;
    while (idx < limit && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        done_mat_mul = 1'b0;
        vectors++;
        if (start_mat_mul !== 1'b0 || busy !== 1'b1) begin
          miscompares++;
          $display("FAIL drain_entry: smm=%b busy=%b, required 0/1", start_mat_mul, busy);
        end
      end
      if (stalled) begin
        vectors++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          miscompares++;
          $display("FAIL stall_hold: valid=%b data=%h, required 1 and %h", out_valid, out_data, held);
        end
      end
      out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
      if (out_valid === 1'b1 && out_ready) begin
        if (first_cyc == 0) first_cyc = cyc;
        else if (cyc != last_acc + 1) gaps++;
        last_acc = cyc;
        vectors++;
        if (out_data !== cword(idx / DEPTH, idx % DEPTH, salt) ||
            out_last !== (idx == NWORDS - 1)) begin
          miscompares++;
          $display("FAIL word_%0d: data=%h last=%b, required %h last=%b", idx, out_data, out_last,
                   cword(idx / DEPTH, idx % DEPTH, salt), idx == NWORDS - 1);
        end
        idx++;
      end
      stalled = out_valid && !out_ready;
      held = out_data;
    end
    vectors++;
    if (idx != limit) begin
      miscompares++;
      $display("FAIL drain_count: got %0d words, required %0d", idx, limit);
    end
    if (reset_at > 0) begin
      @(negedge clk);
      reset = 1'b1;
      exp_error = 1'b0;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || start_mat_mul !== 1'b0 || c_addr !== '0 ||
          error !== 1'b0 || out_last !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid_drain: valid=%b busy=%b smm=%b c_addr=%0d err=%b, required 0",
                 out_valid, busy, start_mat_mul, c_addr, error);
      end
      @(negedge clk); reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL post_reset_quiet: valid=%b, required 0", out_valid);
        end
      end
    end else begin
      if (!rand_ready) begin
        vectors++;
        if (first_cyc != 3 || gaps != 0) begin
          miscompares++;
          $display("FAIL throughput: first word cycle %0d gaps %0d, required 3 and 0", first_cyc, gaps);
        end
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || out_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL flush_state: busy=%b valid=%b, required 1/0", busy, out_valid);
      end
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || host_wr_ready !== 1'b1 || error !== exp_error) begin
        miscompares++;
        $display("FAIL back_to_idle: busy=%b ready=%b err=%b, required 0/1/%b",
                 busy, host_wr_ready, error, exp_error);
      end
    end
  endtask

  task automatic test_errors();
    do_write(1'b0, 3'd3, 7'd2, {8{32'($urandom)}}, "write_bad_bank");
    run_drain(1'b1, 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid_drain();
    run_drain(1'b0, 1'b0, 10, 1'b0);
    run_drain(1'b1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_single_word();
    int cyc;
    bit got;
    salt = 16'($urandom);
    s_start = 1'b1;
    @(negedge clk); s_start = 1'b0;
    repeat (3) @(negedge clk);
    s_done = 1'b1;
    @(negedge clk); s_done = 1'b0;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      cyc++;
      if (s_out_valid === 1'b1) begin
        got = 1'b1;
        vectors++;
        if (s_out_data !== cword(0, 0, salt) || s_out_last !== 1'b1) begin
          miscompares++;
          $display("FAIL single_word: data=%h last=%b, required %h last=1",
                   s_out_data, s_out_last, cword(0, 0, salt));
        end
      end
      @(negedge clk);
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL single_word_timeout: no word within 50 cycles, required one");
    end
    @(negedge clk);
    vectors++;
    if (s_busy !== 1'b0 || s_out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_word_idle: busy=%b valid=%b, required 0/0", s_busy, s_out_valid);
    end
  endtask

  initial begin
    reset = 1'b1; exp_error = 1'b0; salt = 16'h0;
    host_wr_valid = 1'b0; host_wr_mat = 1'b0; host_wr_bank = '0; host_wr_addr = '0; host_wr_data = '0;
    start = 1'b0; done_mat_mul = 1'b0; out_ready = 1'b0;
    s_wr_valid = 1'b0; s_wr_mat = 1'b0; s_wr_bank = '0; s_wr_addr = '0; s_wr_data = '0;
    s_start = 1'b0; s_done = 1'b0; s_out_ready = 1'b1;
    test_reset();
    test_host_write();
    run_drain(1'b0, 1'b0, 0, 1'b0);
    run_drain(1'b1, 1'b0, 0, 1'b1);
    test_errors();
    test_reset_mid_drain();
    test_single_word();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/matmul_host_sequencer.md
MATMUL_HOST_SEQUENCER -- requirements
Module: matmul_host_sequencer

Interface
REQ-001 SHALL have parameter DWIDTH, default 16, element width in bits.
REQ-002 SHALL have parameter AWIDTH, default 7, BRAM address width.
REQ-003 SHALL have parameter BB_MAT_MUL_SIZE, default 16, elements per BRAM word.
REQ-004 SHALL have parameter NUM_TILES, default 2, tile-grid dimension; A, B and C banks per matrix; range 1..8.
REQ-005 SHALL have parameter C_DEPTH, default 16, C words read per bank; range 1..2**AWIDTH.
REQ-006 SHALL have ports: clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high.
REQ-008 host_wr_valid  in  1; host_wr_ready  out  1; host_wr_mat  in  1 (0=A, 1=B); host_wr_bank  in  3; host_wr_addr  in  AWIDTH; host_wr_data  in  BB_MAT_MUL_SIZE*DWIDTH.
REQ-009 start  in  1  pulse, begin compute; busy  out  1.
REQ-010 start_mat_mul  out  1  level to tile array; done_mat_mul  in  1  from array.
REQ-011 a_we, b_we  out  NUM_TILES  one-hot bank write enables; mem_addr  out  AWIDTH; mem_wdata  out  BB_MAT_MUL_SIZE*DWIDTH.
REQ-012 c_addr  out  AWIDTH; c_q  in  NUM_TILES*BB_MAT_MUL_SIZE*DWIDTH, bank k at slice k, registered BRAM output, 1-cycle read latency.
REQ-013 out_valid  out  1; out_ready  in  1; out_data  out  BB_MAT_MUL_SIZE*DWIDTH; out_last  out  1.
REQ-014 error  out  1  sticky protocol error flag.

Function
REQ-015 FSM states: IDLE, COMPUTE, DRAIN, FLUSH; transitions only as in REQ-016..REQ-021.
REQ-016 IDLE: host_wr_ready=1; valid&&ready write is registered: one cycle later the selected a_we/b_we bit is 1 for exactly one cycle with mem_addr/mem_wdata holding the written values.
REQ-017 IDLE, host_wr_bank>=NUM_TILES: write accepted but dropped (no we bit), error set.
REQ-018 IDLE, start=1 -> COMPUTE next cycle; start_mat_mul=1 throughout COMPUTE; same-cycle host write and start: write completes, then COMPUTE.
REQ-019 COMPUTE: host_wr_ready=0, start ignored; done_mat_mul=1 -> DRAIN, start_mat_mul deasserts next cycle.
REQ-020 DRAIN: reads bank 0 addresses 0..C_DEPTH-1, then bank 1, ..., bank NUM_TILES-1; c_addr driven from word counter; out_data is the selected bank slice of c_q.
REQ-021 DRAIN: read issued only if (output-buffer occupancy + reads in flight) < 2; 2-entry output buffer; no word lost or duplicated under any out_ready pattern.
REQ-022 out_data/out_valid SHALL hold stable while out_valid && !out_ready.
REQ-023 out_last=1 only with the final word (bank NUM_TILES-1, address C_DEPTH-1); its acceptance -> FLUSH.
REQ-024 FLUSH: one cycle, counters cleared -> IDLE.
REQ-025 busy=1 in COMPUTE, DRAIN, FLUSH.
REQ-026 start while busy is ignored and sets error; error clears only by reset.
REQ-027 Zero-bubble throughput: with out_ready held 1, one word per cycle after 2-cycle initial latency from DRAIN entry.
REQ-028 Counters wrap only via FLUSH clear, never mid-drain.

Reset
REQ-029 Asserting reset asynchronously forces IDLE; all outputs 0 except host_wr_ready=1 once deasserted; counters, buffer and error cleared.
REQ-030 Reset mid-COMPUTE or mid-DRAIN SHALL drop buffered words; no out_valid until the next completed COMPUTE.

Structure
REQ-031 Shared package SHALL hold FSM state encoding and default DWIDTH/AWIDTH/BB_MAT_MUL_SIZE constants.
REQ-032 The 2-entry output buffer SHALL be a sub-module matmul_out_skid (parametrised width, valid/ready both sides).

Verification
REQ-033 Write A bank 1 addr 5 data 0x1234 pattern -> a_we=2'b10, mem_addr=5 exactly one cycle, next cycle a_we=0.
REQ-034 NUM_TILES=2, C_DEPTH=16, out_ready=1 -> start, done after 40 cycles -> 32 words, bank0 0..15 then bank1 0..15, out_last on word 32 only, busy drops after FLUSH.
REQ-035 Same, out_ready toggling pseudorandom 50% -> identical 32-word sequence, out_data stable when stalled.
REQ-036 start during COMPUTE, write to bank 3 with NUM_TILES=2 -> error=1, no we pulse, sequence unaffected.
REQ-037 reset asserted at word 10 of drain -> outputs 0 immediately; next run emits full 32 words from word 0.
REQ-038 NUM_TILES=1, C_DEPTH=1 -> single word with out_last=1, then IDLE.
